// File: rtl/mmio_pwm_bank_if.sv
// CPU register bus seen by mmio_pwm_bank: strobes, word address, write data and
// registered read data.
interface mmio_pwm_bank_if;
    logic        read_enable;
    logic        write_enable;
    logic [15:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data;

    modport master (
        output read_enable, write_enable, address, write_data,
        input  read_data
    );

    modport slave (
        input  read_enable, write_enable, address, write_data,
        output read_data
    );
endinterface

// File: rtl/mmio_pwm_bank.sv
// Multi-channel memory-mapped PWM with a shared period, duty shadows latched on wrap
// and per-channel auto mode driven by the ADC sample stream.
module mmio_pwm_bank #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned SAMPLE_WIDTH = 10,
    parameter logic [15:0] BASE_ADDR    = 16'h8000
) (
    input  logic                    clock,
    input  logic                    reset,
    mmio_pwm_bank_if.slave          bus,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    sample_valid,
    output logic [CHANNELS-1:0]     pulse,
    output logic                    period_tick
);
    logic [15:0]         offset;
    logic                in_window;
    logic                ctrl_sel;
    logic                period_sel;
    logic                status_sel;
    logic [CHANNELS-1:0] duty_sel;

    logic [CHANNELS-1:0] enable_q;
    logic [CHANNELS-1:0] auto_q;
    logic [WIDTH-1:0]    period_q;
    logic [WIDTH-1:0]    counter_q;
    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    active_q [CHANNELS];
    logic                wrap_flag_q;
    logic [CHANNELS-1:0] pulse_q;
    logic [CHANNELS-1:0] pulse_d;
    logic                tick_q;
    logic [15:0]         read_data_q;
    logic [15:0]         rd_value;
    logic [WIDTH-1:0]    sample_duty;
    logic                wrap;
    logic                unused_inputs;

    // Window check by subtraction so an unaligned BASE_ADDR still decodes correctly.
    assign offset     = bus.address - BASE_ADDR;
    assign in_window  = offset < 16'd16;
    assign ctrl_sel   = in_window && (offset[3:0] == 4'd0);
    assign period_sel = in_window && (offset[3:0] == 4'd1);
    assign status_sel = in_window && (offset[3:0] == 4'd2);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_duty_sel
        assign duty_sel[i] = in_window && (offset[3:0] == 4'(4 + i));
    end

    if (SAMPLE_WIDTH >= WIDTH) begin : g_sample_msb
        assign sample_duty = sample[SAMPLE_WIDTH-1 -: WIDTH];
    end else begin : g_sample_zext
        assign sample_duty = {{(WIDTH - SAMPLE_WIDTH){1'b0}}, sample};
    end

    assign unused_inputs = ^{bus.write_data, sample};

    assign wrap = counter_q >= period_q;

    // CPU write beats an auto-mode sample arriving in the same cycle.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (bus.write_enable && duty_sel[i]) begin
                shadow_d[i] = bus.write_data[WIDTH-1:0];
            end else if (auto_q[i] && sample_valid) begin
                shadow_d[i] = sample_duty;
            end
        end
    end

    always_comb begin
        rd_value = '0;
        if (ctrl_sel) begin
            rd_value[CHANNELS-1:0] = enable_q;
            rd_value[8 +: CHANNELS] = auto_q;
        end
        if (period_sel) rd_value[WIDTH-1:0] = period_q;
        if (status_sel) rd_value[0] = wrap_flag_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (duty_sel[i]) rd_value[WIDTH-1:0] = shadow_q[i];
        end
    end

    always_comb begin
        pulse_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pulse_d[i] = enable_q[i] && (counter_q < active_q[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter_q   <= '0;
            period_q    <= '1;
            enable_q    <= '0;
            auto_q      <= '0;
            wrap_flag_q <= 1'b0;
            pulse_q     <= '0;
            tick_q      <= 1'b0;
            read_data_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            counter_q <= wrap ? '0 : counter_q + WIDTH'(1);
            tick_q    <= wrap;
            if (bus.write_enable && ctrl_sel) begin
                enable_q <= bus.write_data[CHANNELS-1:0];
                auto_q   <= bus.write_data[8 +: CHANNELS];
            end
            if (bus.write_enable && period_sel) period_q <= bus.write_data[WIDTH-1:0];
            // A wrap in the same cycle as a STATUS read keeps the flag set.
            if (wrap) begin
                wrap_flag_q <= 1'b1;
            end else if (bus.read_enable && status_sel) begin
                wrap_flag_q <= 1'b0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (wrap) active_q[i] <= shadow_d[i];
            end
            pulse_q     <= pulse_d;
            read_data_q <= bus.read_enable ? rd_value : '0;
        end
    end

    assign pulse         = pulse_q;
    assign period_tick   = tick_q;
    assign bus.read_data = read_data_q;
endmodule

// File: tb/tb_mmio_pwm_bank.sv
// Self-checking bench for mmio_pwm_bank: randomized register and PWM scenarios against
// a high-level model (high-cycle counts per period, register array).
module tb_mmio_pwm_bank;
    localparam logic [15:0] BASE = 16'h8000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] sample = '0;
    logic       sample_valid = 1'b0;
    logic [3:0] pulse;
    logic       period_tick;

    mmio_pwm_bank_if bus();

    mmio_pwm_bank #(
        .CHANNELS(4), .WIDTH(8), .SAMPLE_WIDTH(10), .BASE_ADDR(16'h8000)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus), .sample(sample),
        .sample_valid(sample_valid), .pulse(pulse), .period_tick(period_tick)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int meas_highs [4];
    bit meas_shape_ok;
    bit meas_tick_ok;

    function automatic int exp_highs(bit en, int duty, int plen);
        if (!en) return 0;
        return (duty < plen) ? duty : plen;
    endfunction

    task automatic bus_cycle(input bit re, input bit we, input logic [15:0] addr,
                             input logic [15:0] wdata, input bit sv, input logic [9:0] smp,
                             output logic [15:0] rd);
        @(negedge clock);
        bus.read_enable  = re;
        bus.write_enable = we;
        bus.address      = addr;
        bus.write_data   = wdata;
        sample_valid     = sv;
        sample           = smp;
        @(negedge clock);
        bus.read_enable  = 1'b0;
        bus.write_enable = 1'b0;
        sample_valid     = 1'b0;
        rd = bus.read_data;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        logic [15:0] d;
        bus_cycle(1'b0, 1'b1, addr, data, 1'b0, 10'd0, d);
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
        bus_cycle(1'b1, 1'b0, addr, 16'd0, 1'b0, 10'd0, data);
    endtask

    task automatic do_reset();
        bus.read_enable = 1'b0; bus.write_enable = 1'b0;
        bus.address = '0; bus.write_data = '0;
        sample_valid = 1'b0; sample = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clock);
            if (period_tick) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: period_tick observed=0 required=1 within 1000 cycles", name);
        end
    endtask

    // Starts on a tick sample; samples one full period of plen cycles, optionally
    // writing wr_data to wr_addr at sample wr_at.
    task automatic measure(input int plen, input int wr_at, input logic [15:0] wr_addr,
                           input logic [15:0] wr_data);
        bit seen_low [4];
        for (int c = 0; c < 4; c++) begin meas_highs[c] = 0; seen_low[c] = 1'b0; end
        meas_shape_ok = 1'b1;
        meas_tick_ok  = 1'b1;
        for (int i = 1; i <= plen; i++) begin
            @(negedge clock);
            if (wr_at != 0 && i == wr_at + 1) bus.write_enable = 1'b0;
            for (int c = 0; c < 4; c++) begin
                if (pulse[c]) begin
                    meas_highs[c]++;
                    if (seen_low[c]) meas_shape_ok = 1'b0;
                end else begin
                    seen_low[c] = 1'b1;
                end
            end
            if (period_tick != (i == plen)) meas_tick_ok = 1'b0;
            if (wr_at != 0 && i == wr_at) begin
                bus.write_enable = 1'b1; bus.address = wr_addr; bus.write_data = wr_data;
            end
        end
    endtask

    task automatic test_reset();
        int first = -1;
        logic [15:0] d;
        reset = 1'b1;
        #1;
        checks++;
        if ({pulse, period_tick, bus.read_data} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got pulse=%h tick=%b rd=%h required all 0",
                     pulse, period_tick, bus.read_data);
        end
        do_reset();
        for (int i = 1; i <= 300; i++) begin
            @(negedge clock);
            if (period_tick && first < 0) first = i;
        end
        checks++;
        if (first != 256) begin
            errors++;
            $display("FAIL reset_first_tick: got cycle %0d required 256", first);
        end
        bus_read(BASE + 16'd0, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_ctrl: got %h required 0000", d); end
        bus_read(BASE + 16'd1, d);
        checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL reset_period: got %h required 00FF", d); end
        bus_read(BASE + 16'd4, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reset_duty0: got %h required 0000", d); end
        bus_read(BASE + 16'd2, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL reset_status_after_wrap: got %h required 0001", d); end
    endtask

    task automatic test_basic_and_glitch();
        do_reset();
        bus_write(BASE + 16'd1, 16'd9);
        bus_write(BASE + 16'd4, 16'd3);
        bus_write(BASE + 16'd0, 16'h0001);
        wait_tick("basic_first_wrap");
        measure(10, 0, 16'd0, 16'd0);
        checks++;
        if (meas_highs[0] != 3 || !meas_shape_ok || !meas_tick_ok || meas_highs[1] != 0 ||
            meas_highs[2] != 0 || meas_highs[3] != 0) begin
            errors++;
            $display("FAIL basic_pwm: got highs=%0d/%0d/%0d/%0d shape=%b tick=%b required 3/0/0/0 1 1",
                     meas_highs[0], meas_highs[1], meas_highs[2], meas_highs[3],
                     meas_shape_ok, meas_tick_ok);
        end
        measure(10, 4, BASE + 16'd4, 16'd7);
        checks++;
        if (meas_highs[0] != 3 || !meas_shape_ok || !meas_tick_ok) begin
            errors++;
            $display("FAIL glitch_current: got highs=%0d shape=%b tick=%b required 3 1 1",
                     meas_highs[0], meas_shape_ok, meas_tick_ok);
        end
        measure(10, 0, 16'd0, 16'd0);
        checks++;
        if (meas_highs[0] != 7 || !meas_shape_ok || !meas_tick_ok) begin
            errors++;
            $display("FAIL glitch_next: got highs=%0d shape=%b tick=%b required 7 1 1",
                     meas_highs[0], meas_shape_ok, meas_tick_ok);
        end
    endtask

    task automatic test_duty_bounds();
        do_reset();
        bus_write(BASE + 16'd1, 16'd9);
        bus_write(BASE + 16'd5, 16'd0);
        bus_write(BASE + 16'd6, 16'd12);
        bus_write(BASE + 16'd0, 16'h0006);
        wait_tick("bounds_wrap");
        measure(10, 0, 16'd0, 16'd0);
        checks++;
        if (meas_highs[0] != 0 || meas_highs[1] != 0 || meas_highs[2] != 10 || meas_highs[3] != 0) begin
            errors++;
            $display("FAIL duty_bounds: got highs=%0d/%0d/%0d/%0d required 0/0/10/0",
                     meas_highs[0], meas_highs[1], meas_highs[2], meas_highs[3]);
        end
    endtask

    task automatic test_random_pwm();
        int plen;
        int duty [4];
        logic [3:0] en;
        do_reset();
        for (int it = 0; it < 4; it++) begin
            plen = $urandom_range(2, 24);
            en   = 4'($urandom_range(0, 15));
            for (int c = 0; c < 4; c++) duty[c] = $urandom_range(0, plen + 3);
            bus_write(BASE + 16'd1, 16'(plen - 1));
            for (int c = 0; c < 4; c++) bus_write(BASE + 16'(4 + c), 16'(duty[c]));
            bus_write(BASE + 16'd0, {12'd0, en});
            wait_tick("random_wrap");
            measure(plen, 0, 16'd0, 16'd0);
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (meas_highs[c] != exp_highs(en[c], duty[c], plen)) begin
                    errors++;
                    $display("FAIL random_pwm ch%0d: got %0d high cycles required %0d (period %0d duty %0d en %b)",
                             c, meas_highs[c], exp_highs(en[c], duty[c], plen), plen, duty[c], en[c]);
                end
            end
            checks++;
            if (!meas_shape_ok || !meas_tick_ok) begin
                errors++;
                $display("FAIL random_shape: got shape=%b tick=%b required 1 1 (period %0d)",
                         meas_shape_ok, meas_tick_ok, plen);
            end
        end
    endtask

    task automatic test_auto_mode();
        logic [15:0] d;
        logic [9:0]  s;
        do_reset();
        bus_write(BASE + 16'd1, 16'd255);
        bus_write(BASE + 16'd5, 16'h0055);
        bus_write(BASE + 16'd0, 16'h0101);
        bus_cycle(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 10'h3FF, d);
        bus_read(BASE + 16'd4, d);
        checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL auto_duty0: got %h required 00FF", d); end
        bus_read(BASE + 16'd5, d);
        checks++; if (d !== 16'h0055) begin errors++; $display("FAIL auto_duty1_untouched: got %h required 0055", d); end
        for (int it = 0; it < 3; it++) begin
            s = 10'($urandom);
            bus_cycle(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, s, d);
            bus_read(BASE + 16'd4, d);
            checks++;
            if (d !== 16'(s >> 2)) begin
                errors++;
                $display("FAIL auto_random: got %h required %h (sample %h)", d, 16'(s >> 2), s);
            end
        end
        bus_cycle(1'b0, 1'b0, 16'd0, 16'd0, 1'b1, 10'h3FF, d);
        wait_tick("auto_wrap");
        measure(256, 0, 16'd0, 16'd0);
        checks++;
        if (meas_highs[0] != 255 || !meas_tick_ok) begin
            errors++;
            $display("FAIL auto_pwm: got highs=%0d tick=%b required 255 1", meas_highs[0], meas_tick_ok);
        end
        bus_cycle(1'b0, 1'b1, BASE + 16'd4, 16'h0010, 1'b1, 10'($urandom), d);
        bus_read(BASE + 16'd4, d);
        checks++; if (d !== 16'h0010) begin errors++; $display("FAIL auto_cpu_wins: got %h required 0010", d); end
    endtask

    task automatic test_period_shrink();
        logic [15:0] d;
        do_reset();
        wait_tick("shrink_wrap");
        repeat (200) @(negedge clock);
        bus.write_enable = 1'b1; bus.address = BASE + 16'd1; bus.write_data = 16'd50;
        @(negedge clock);
        bus.write_enable = 1'b0;
        checks++;
        if (period_tick !== 1'b0) begin errors++; $display("FAIL shrink_no_early_tick: got %b required 0", period_tick); end
        @(negedge clock);
        checks++;
        if (period_tick !== 1'b1) begin errors++; $display("FAIL shrink_tick: got %b required 1", period_tick); end
        measure(51, 0, 16'd0, 16'd0);
        checks++;
        if (!meas_tick_ok) begin errors++; $display("FAIL shrink_spacing: got tick_ok=0 required 1"); end
        bus_read(BASE + 16'd2, d);
        checks++; if (d !== 16'h0001) begin errors++; $display("FAIL status_set: got %h required 0001", d); end
        bus_read(BASE + 16'd2, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL status_cleared: got %h required 0000", d); end
    endtask

    task automatic test_period_zero();
        logic [15:0] d;
        int bad = 0;
        do_reset();
        bus_write(BASE + 16'd1, 16'd0);
        bus_write(BASE + 16'd4, 16'd1);
        bus_write(BASE + 16'd0, 16'h0001);
        repeat (2) @(negedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (period_tick !== 1'b1 || pulse[0] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL period_zero: got %0d bad cycles required 0", bad); end
        bus_read(BASE + 16'd2, d);
        bus_read(BASE + 16'd2, d);
        checks++;
        if (d !== 16'h0001) begin errors++; $display("FAIL status_wrap_during_read: got %h required 0001", d); end
    endtask

    task automatic test_reset_async();
        logic [15:0] d;
        do_reset();
        bus_write(BASE + 16'd1, 16'd9);
        bus_write(BASE + 16'd4, 16'd12);
        bus_write(BASE + 16'd0, 16'h0001);
        wait_tick("async_wrap");
        bus.read_enable = 1'b1; bus.address = BASE + 16'd1;
        @(negedge clock);
        checks++;
        if (pulse[0] !== 1'b1 || bus.read_data !== 16'd9) begin
            errors++;
            $display("FAIL async_pre: got pulse=%b rd=%h required 1 0009", pulse[0], bus.read_data);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (pulse !== 4'd0 || bus.read_data !== 16'd0 || period_tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got pulse=%h rd=%h tick=%b required 0 0000 0",
                     pulse, bus.read_data, period_tick);
        end
        bus.read_enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        bus_read(BASE + 16'd1, d);
        checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL async_period: got %h required 00FF", d); end
    endtask

    task automatic test_rw_random();
        logic [3:0]  m_en, m_auto;
        logic [7:0]  m_period;
        logic [7:0]  m_duty [4];
        logic [15:0] d, exp, addr, wdata;
        int off, kind;
        bit re, we;
        do_reset();
        m_en = '0; m_auto = '0; m_period = 8'hFF;
        for (int c = 0; c < 4; c++) m_duty[c] = '0;
        for (int it = 0; it < 40; it++) begin
            off   = $urandom_range(0, 17);
            kind  = $urandom_range(0, 3);
            wdata = 16'($urandom);
            addr  = (off == 17) ? BASE - 16'd1 : BASE + 16'(off);
            re = (kind != 0) && (off != 2);
            we = (kind == 0) || (kind == 2);
            exp = '0;
            if (off == 0) exp = {4'd0, m_auto, 4'd0, m_en};
            else if (off == 1) exp = {8'd0, m_period};
            else if (off >= 4 && off <= 7) exp = {8'd0, m_duty[off-4]};
            bus_cycle(re, we, addr, wdata, 1'b0, 10'd0, d);
            if (re) begin
                checks++;
                if (d !== exp) begin
                    errors++;
                    $display("FAIL rw_random off=%0d we=%b: got %h required %h", off, we, d, exp);
                end
            end
            if (we) begin
                if (off == 0) begin m_en = wdata[3:0]; m_auto = wdata[11:8]; end
                else if (off == 1) m_period = wdata[7:0];
                else if (off >= 4 && off <= 7) m_duty[off-4] = wdata[7:0];
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        bus.read_enable = 1'b0; bus.write_enable = 1'b0;
        bus.address = '0; bus.write_data = '0;
        test_reset();
        test_basic_and_glitch();
        test_duty_bounds();
        test_random_pwm();
        test_auto_mode();
        test_period_shrink();
        test_period_zero();
        test_reset_async();
        test_rw_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
